pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register. It is the generic successor to the fixed-field inter-stage registers between ID/EX, EX/MEM and MEM/WB. It carries an opaque data payload and a control payload from producer stage to consumer stage with valid/ready backpressure, an optional skid entry for full throughput under stall, and flush that squashes to a NOP bubble while preserving a pass-through field such as the PC. Saturating bubble and flush counters feed the performance monitor.

## Interface
- DATA_W, 128: data payload width (operands, immediate, PC, etc.); must be ≥ KEEP_W.
- CTRL_W, 12: control payload width (ALUop, RegWrite, MemRead, ...); forced to 0 in every bubble.
- KEEP_W, 32: low data bits that still load from the input on flush (PC pass-through); 0 disables.
- SKID, 1: 1 adds one skid entry and a registered in_ready_o; 0 gives a single entry with combinational ready.

- sys_clk  in  1  clock, rising edge.
- sys_start  in  1  reset; one clock; asynchronous assert, active-low.
- flush_i  in  1  squash all held entries and the current input.
- in_valid_i  in  1  producer has an entry.
- in_ready_o  out  1  stage can accept an entry this cycle.
- in_data_i  in  DATA_W  producer data payload.
- in_ctrl_i  in  CTRL_W  producer control payload.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  consumer accepts the entry.
- out_data_o  out  DATA_W  output data payload.
- out_ctrl_o  out  CTRL_W  output control payload; all-zero whenever out_valid_o=0.
- bubble_cnt_o  out  16  cycles with out_valid_o=0, saturating.
- flush_cnt_o  out  8  flush cycles, saturating.

## Operation
- Storage: main entry (drives the outputs) plus skid entry (SKID=1 only). Order is strict FIFO. Maximum occupancy is 1+SKID.
- Accept: in_valid_i & in_ready_o & ~flush_i. Emit: out_valid_o & out_ready_i.
- in_ready_o:
  - SKID=1: ~skid_valid, driven from a register.
  - SKID=0: ~out_valid_o | out_ready_i, combinational.
- Next-state, when no flush:
  - Main empty, or main emitting with skid empty: an accepted input loads main.
  - Main emitting with skid full: skid moves to main. No accept is possible because in_ready_o=0.
  - Main full and not emitting: an accepted input loads skid.
  - Main emitting with nothing to load: main becomes empty, and out_ctrl_o is cleared to 0.
- Flush (highest priority below reset):
  - Next edge sets out_valid_o=0 and skid_valid=0, and the input is dropped.
  - out_ctrl_o is set to 0.
  - out_data_o[DATA_W-1:KEEP_W] is set to 0, and out_data_o[KEEP_W-1:0] loads in_data_i[KEEP_W-1:0] regardless of in_valid_i.
  - An emit in the same cycle as flush still counts as consumed by the consumer.
- Empty without flush: out_data_o holds its last value and out_ctrl_o is 0.
- Counters:
  - bubble_cnt_o increments on each edge where the pre-edge out_valid_o=0 and sticks at 0xFFFF.
  - flush_cnt_o increments on each edge where flush_i=1 and sticks at 0xFF.
  - Both counters clear only on reset.

## Timing
- Reset (sys_start=0, asynchronous):
  - Outputs: out_valid_o=0, out_data_o=0, out_ctrl_o=0, bubble_cnt_o=0, flush_cnt_o=0.
  - in_ready_o=1 in both modes; skid_valid=0.
- Release of reset is synchronous to sys_clk. The first accept can happen on the first rising edge after release.
- Latency: an entry accepted at edge N is on the outputs with out_valid_o=1 after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle with out_ready_i held 1.
- SKID=1 under stall: one further entry is accepted, then in_ready_o drops after that edge. in_ready_o rises after the edge where skid moves to main.
- SKID=0: in_ready_o follows out_ready_i in the same cycle, so there is no bubble on stall release.
- out_valid_o must not drop without an emit or flush. out_data_o/out_ctrl_o must be stable while out_valid_o=1 and out_ready_i=0.
- Flush together with in_valid_i: the entry is not accepted and in_ready_o does not gate the drop. The stage is empty after the edge, and in_ready_o=1 on the next cycle.

## Test plan
- Reset mid-stream: with both entries full, assert sys_start=0 between edges -> outputs zero immediately, in_ready_o=1, both counters 0.
- Streaming, SKID=1, out_ready_i=1: feed data 0x10..0x17 with ctrl 0x5A5 -> same sequence out one cycle later, no gaps, bubble_cnt_o frozen.
- Stall, SKID=1: out_ready_i=0 while feeding A,B,C -> A in main, B in skid, in_ready_o=0, C held by producer. Release -> A, B, C emitted in order on consecutive cycles.
- Flush with full stage: flush_i=1 with in_data_i low 32 bits=0x0000_0400 -> next cycle out_valid_o=0, out_ctrl_o=0, out_data_o=0x...0000_0400 with upper bits zero, flush_cnt_o +1, input not delivered.
- SKID=0 build, alternating out_ready_i 1/0 -> in_ready_o mirrors out_ready_i while full, no loss, no duplication.
- Saturation: preload by idling 65535+3 cycles and by 258 flushes -> bubble_cnt_o=0xFFFF, flush_cnt_o=0xFF, no wrap.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Handshaked inter-stage pipeline register with optional skid entry, flush-to-bubble
// that keeps the low pass-through data bits, and saturating bubble/flush counters.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 12,
    parameter int KEEP_W = 32,
    parameter int SKID   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_start,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [15:0]       bubble_cnt_o,
    output logic [7:0]        flush_cnt_o
);

    logic              main_valid_reg, main_valid_next;
    logic [DATA_W-1:0] main_data_reg,  main_data_next;
    logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
    logic [15:0]       bubble_cnt_reg, bubble_cnt_next;
    logic [7:0]        flush_cnt_reg,  flush_cnt_next;
    logic [DATA_W-1:0] flush_data;
    logic              accept;
    logic              emit;

    // Flush image: low KEEP_W bits pass through from the input, the rest clear.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flush_data
        if (gi < KEEP_W) begin : g_keep
            assign flush_data[gi] = in_data_i[gi];
        end else begin : g_clear
            assign flush_data[gi] = 1'b0;
        end
    end

    assign accept = in_valid_i & in_ready_o & ~flush_i;
    assign emit   = main_valid_reg & out_ready_i;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_ctrl_next  = main_ctrl_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        if (flush_i) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
            main_ctrl_next  = '0;
            main_data_next  = flush_data;
        end else if (!main_valid_reg || emit) begin
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                main_ctrl_next  = skid_ctrl_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_valid_next = 1'b1;
                main_data_next  = in_data_i;
                main_ctrl_next  = in_ctrl_i;
            end else begin
                // Going empty: data holds, control becomes a bubble.
                main_valid_next = 1'b0;
                main_ctrl_next  = '0;
            end
        end else if (accept && (SKID != 0)) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data_i;
            skid_ctrl_next  = in_ctrl_i;
        end
    end

    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        flush_cnt_next  = flush_cnt_reg;
        if (!main_valid_reg && (bubble_cnt_reg != 16'hFFFF)) begin
            bubble_cnt_next = bubble_cnt_reg + 16'd1;
        end
        if (flush_i && (flush_cnt_reg != 8'hFF)) begin
            flush_cnt_next = flush_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_ctrl_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_ctrl_reg  <= main_ctrl_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            bubble_cnt_reg <= bubble_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    if (SKID != 0) begin : g_skid_ready
        logic ready_reg;

        // Registered ready breaks the combinational path from out_ready_i upstream.
        always_ff @(posedge sys_clk or negedge sys_start) begin
            if (!sys_start) begin
                ready_reg <= 1'b1;
            end else begin
                ready_reg <= ~skid_valid_next;
            end
        end

        assign in_ready_o = ready_reg;
    end else begin : g_comb_ready
        assign in_ready_o = ~main_valid_reg | out_ready_i;
    end

    assign out_valid_o  = main_valid_reg;
    assign out_data_o   = main_data_reg;
    assign out_ctrl_o   = main_ctrl_reg;
    assign bubble_cnt_o = bubble_cnt_reg;
    assign flush_cnt_o  = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [127:0] d;
        logic [11:0]  c;
    } item_t;

    logic         sys_clk;
    logic         rst_n;

    logic         flush1, iv1, ir1, ov1, or1;
    logic [127:0] id1, od1;
    logic [11:0]  ic1, oc1;
    logic [15:0]  bc1;
    logic [7:0]   fc1;

    logic         flush0, iv0, ir0, ov0, or0;
    logic [127:0] id0, od0;
    logic [11:0]  ic0, oc0;
    logic [15:0]  bc0;
    logic [7:0]   fc0;

    item_t q1[$];
    item_t q0[$];
    int    checks;
    int    errors;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(12), .KEEP_W(32), .SKID(1)) u_dut1 (
        .sys_clk(sys_clk), .sys_start(rst_n), .flush_i(flush1),
        .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(id1), .in_ctrl_i(ic1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .out_ctrl_o(oc1),
        .bubble_cnt_o(bc1), .flush_cnt_o(fc1)
    );

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(12), .KEEP_W(32), .SKID(0)) u_dut0 (
        .sys_clk(sys_clk), .sys_start(rst_n), .flush_i(flush0),
        .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(id0), .in_ctrl_i(ic0),
        .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0), .out_ctrl_o(oc0),
        .bubble_cnt_o(bc0), .flush_cnt_o(fc0)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drive one entry into the SKID=1 instance; record it when the handshake will complete.
    task automatic put1(input logic [127:0] d, input logic [11:0] c);
        item_t e;
        @(posedge sys_clk); #1;
        iv1 = 1'b1; id1 = d; ic1 = c;
        for (int k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            if (ir1) begin
                e.d = d; e.c = c;
                q1.push_back(e);
                return;
            end
            @(posedge sys_clk); #1;
        end
        checks++; errors++;
        $display("FAIL put1_timeout: got in_ready=0 for 50 cycles required 1");
    endtask

    // Monitor: pop and compare on every emit, independent of the stimulus.
    always @(negedge sys_clk) begin
        item_t e;
        if (rst_n) begin
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_unexpected_emit: got data=%0h ctrl=%0h required none", od1, oc1);
                end else begin
                    e = q1.pop_front();
                    $display("dut1 emit data=%0h ctrl=%0h", od1, oc1);
                    chk("dut1_emit_data", od1, e.d);
                    chk("dut1_emit_ctrl", {116'b0, oc1}, {116'b0, e.c});
                end
            end
            if (!ov1) chk("dut1_bubble_ctrl_zero", {116'b0, oc1}, 128'd0);
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_unexpected_emit: got data=%0h ctrl=%0h required none", od0, oc0);
                end else begin
                    e = q0.pop_front();
                    $display("dut0 emit data=%0h ctrl=%0h", od0, oc0);
                    chk("dut0_emit_data", od0, e.d);
                    chk("dut0_emit_ctrl", {116'b0, oc0}, {116'b0, e.c});
                end
            end
            if (!ov0) chk("dut0_bubble_ctrl_zero", {116'b0, oc0}, 128'd0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        item_t e;
        logic  exp_ready;
        logic [127:0] dat;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        flush1 = 0; iv1 = 0; or1 = 0; id1 = '0; ic1 = '0;
        flush0 = 0; iv0 = 0; or0 = 0; id0 = '0; ic0 = '0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_out_valid", {127'b0, ov1}, 128'd0);
        chk("rst_out_data", od1, 128'd0);
        chk("rst_out_ctrl", {116'b0, oc1}, 128'd0);
        chk("rst_in_ready_skid1", {127'b0, ir1}, 128'd1);
        chk("rst_in_ready_skid0", {127'b0, ir0}, 128'd1);
        chk("rst_bubble_cnt", {112'b0, bc1}, 128'd0);
        chk("rst_flush_cnt", {120'b0, fc1}, 128'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("idle_bubble_cnt", {112'b0, bc1}, 128'd3);

        // Streaming at full rate, SKID=1
        or1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put1(128'h10 + 128'(i), 12'h5A5);
            chk("stream_valid", {127'b0, ov1}, (i >= 1) ? 128'd1 : 128'd0);
        end
        @(posedge sys_clk); #1;
        iv1 = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("stream_drained", {127'b0, ov1}, 128'd0);
        chk("stream_bubble_frozen", {112'b0, bc1}, 128'd5);
        #1;
        chk("stream_queue_empty", 128'(q1.size()), 128'd0);

        // Stall with skid, SKID=1
        or1 = 1'b0;
        put1({96'hAAAA, 32'h1}, 12'h001);
        put1({96'hBBBB, 32'h2}, 12'h002);
        chk("stall_main_a", od1, {96'hAAAA, 32'h1});
        @(posedge sys_clk); #1;
        iv1 = 1'b1; id1 = {96'hCCCC, 32'h3}; ic1 = 12'h003;
        @(negedge sys_clk);
        chk("stall_ready_low", {127'b0, ir1}, 128'd0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("stall_ready_held", {127'b0, ir1}, 128'd0);
        chk("stall_data_stable", od1, {96'hAAAA, 32'h1});
        @(posedge sys_clk); #1;
        or1 = 1'b1;
        @(negedge sys_clk);
        chk("release_ready_still_low", {127'b0, ir1}, 128'd0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("release_ready_up", {127'b0, ir1}, 128'd1);
        chk("release_main_b", od1, {96'hBBBB, 32'h2});
        if (ir1) begin
            e.d = {96'hCCCC, 32'h3}; e.c = 12'h003;
            q1.push_back(e);
        end
        @(posedge sys_clk); #1;
        iv1 = 1'b0;
        @(negedge sys_clk);
        chk("release_main_c", od1, {96'hCCCC, 32'h3});
        chk("release_valid_c", {127'b0, ov1}, 128'd1);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("release_drained", {127'b0, ov1}, 128'd0);
        #1;
        chk("release_queue_empty", 128'(q1.size()), 128'd0);

        // Flush with both entries full
        or1 = 1'b0;
        put1({96'hD1, 32'hD1}, 12'h0D1);
        put1({96'hD2, 32'hD2}, 12'h0D2);
        @(posedge sys_clk); #1;
        flush1 = 1'b1; iv1 = 1'b1;
        id1 = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_0400}; ic1 = 12'hFFF;
        @(posedge sys_clk); #1;
        flush1 = 1'b0; iv1 = 1'b0;
        q1.delete();
        @(negedge sys_clk);
        chk("flush_valid", {127'b0, ov1}, 128'd0);
        chk("flush_ctrl", {116'b0, oc1}, 128'd0);
        chk("flush_data_keep", od1, 128'h400);
        chk("flush_ready", {127'b0, ir1}, 128'd1);
        chk("flush_cnt_one", {120'b0, fc1}, 128'd1);
        or1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("flush_no_delivery", {127'b0, ov1}, 128'd0);
        end

        // SKID=0: alternating consumer ready with a producer that never idles
        dat = 128'h100;
        for (int c = 0; c < 12; c++) begin
            @(posedge sys_clk); #1;
            or0 = (c % 2 == 0); iv0 = 1'b1; id0 = dat; ic0 = 12'h0C0 + 12'(c);
            @(negedge sys_clk);
            exp_ready = (c == 0) ? 1'b1 : (c % 2 == 0);
            chk("skid0_ready_mirror", {127'b0, ir0}, {127'b0, exp_ready});
            if (c >= 1) chk("skid0_full", {127'b0, ov0}, 128'd1);
            if (ir0) begin
                e.d = id0; e.c = ic0;
                q0.push_back(e);
                dat = dat + 128'd1;
            end
        end
        @(posedge sys_clk); #1;
        iv0 = 1'b0; or0 = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("skid0_drained", {127'b0, ov0}, 128'd0);
        #1;
        chk("skid0_queue_empty", 128'(q0.size()), 128'd0);

        // Reset asserted between edges with both entries held
        or1 = 1'b0;
        put1({96'hE1, 32'hE1}, 12'h0E1);
        put1({96'hE2, 32'hE2}, 12'h0E2);
        @(posedge sys_clk); #3;
        iv1 = 1'b0;
        chk("pre_reset_full", {127'b0, ov1}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {127'b0, ov1}, 128'd0);
        chk("mid_rst_data", od1, 128'd0);
        chk("mid_rst_ctrl", {116'b0, oc1}, 128'd0);
        chk("mid_rst_ready", {127'b0, ir1}, 128'd1);
        chk("mid_rst_bubble", {112'b0, bc1}, 128'd0);
        chk("mid_rst_flush", {120'b0, fc1}, 128'd0);
        q1.delete();
        q0.delete();

        // Saturation of both counters
        @(negedge sys_clk);
        rst_n = 1'b1; flush1 = 1'b1;
        repeat (255) @(posedge sys_clk);
        #1;
        chk("flush_cnt_255", {120'b0, fc1}, 128'd255);
        chk("bubble_cnt_255", {112'b0, bc1}, 128'd255);
        repeat (3) @(posedge sys_clk);
        #1;
        flush1 = 1'b0;
        chk("flush_cnt_no_wrap", {120'b0, fc1}, 128'hFF);
        chk("bubble_cnt_258", {112'b0, bc1}, 128'd258);
        repeat (65276) @(posedge sys_clk);
        #1;
        chk("bubble_cnt_65534", {112'b0, bc1}, 128'd65534);
        @(posedge sys_clk); #1;
        chk("bubble_cnt_sat", {112'b0, bc1}, 128'hFFFF);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("bubble_cnt_no_wrap", {112'b0, bc1}, 128'hFFFF);
        chk("bubble_cnt_no_wrap_skid0", {112'b0, bc0}, 128'hFFFF);
        chk("flush_cnt_held", {120'b0, fc1}, 128'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
